// File: rtl/fb_scanout.sv
`timescale 1ns/1ps
// Frame-buffer scanout: reads BSRAM port B in raster order and streams pixels on a valid/ready port.
// Latency: start sampled -> first read 1 cycle later -> first pix_valid RD_LAT+2 cycles after start.
// Backpressure: reads are credit-limited to FIFO space, so pix_ready=0 stalls issue without losing data.

// Generic show-ahead FIFO: head entry is always visible while not empty.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: pop only when not empty; a push into a full FIFO is legal only alongside a pop.
module fb_fifo #(
    parameter int W = 11,
    parameter int D = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push_vld,
    input  logic [W-1:0]       push_dat,
    input  logic               pop_rdy,
    output logic [W-1:0]       head_dat,
    output logic               empty,
    output logic [$clog2(D):0] count
);
    localparam int AW = $clog2(D);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = D;

    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  mem_d [D];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_MAX);
    assign count    = cnt_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign do_pop   = pop_rdy && !empty;
    assign do_push  = push_vld && (!full || do_pop);

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Upstream credit accounting must never push into a full FIFO without a matching pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_vld && !flush && full && !do_pop));
endmodule

module fb_scanout #(
    parameter int A_SIZE  = 11,
    parameter int W_SIZE  = 8,
    parameter int H_PIX   = 64,
    parameter int V_LINES = 32,
    parameter int RD_LAT  = 1,
    parameter int FIFO_D  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              fb_ce,
    output logic [A_SIZE-1:0] fb_addr,
    input  logic [W_SIZE-1:0] fb_dout,
    output logic [W_SIZE-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              frame_done
);
    localparam int N  = H_PIX * V_LINES;
    localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int IW = $clog2(RD_LAT + 1);
    localparam int FW = W_SIZE + 3;
    localparam int CW = $clog2(FIFO_D) + 1;

    localparam logic [A_SIZE-1:0] ADDR_LAST = A_SIZE'(N - 1);
    localparam logic [A_SIZE-1:0] ADDR_ONE  = 1;
    localparam logic [XW-1:0]     X_LAST    = XW'(H_PIX - 1);
    localparam logic [XW-1:0]     X_ONE     = 1;
    localparam logic [YW-1:0]     Y_LAST    = YW'(V_LINES - 1);
    localparam logic [YW-1:0]     Y_ONE     = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [W_SIZE-1:0] data;
        logic              sol;
        logic              eol;
        logic              eof;
    } pix_t;

    typedef struct packed {
        logic vld;
        logic sol;
        logic eol;
        logic eof;
    } dl_t;

    state_t            state_q, state_d;
    logic [A_SIZE-1:0] addr_q, addr_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              frame_done_q, frame_done_d;
    dl_t               dl_q [RD_LAT];
    dl_t               dl_d [RD_LAT];

    logic [IW-1:0]     inflight;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    pix_t              push_ent;
    pix_t              head_ent;
    logic              credit;
    logic              issue;
    logic              last;
    logic              iss_sol, iss_eol, iss_eof;
    logic              eof_xfer;

    // Reads still travelling through the BSRAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(dl_q[i].vld);
    end

    assign credit   = (int'(fifo_cnt) + int'(inflight)) < FIFO_D;
    assign issue    = (state_q == RUN) && credit;
    assign last     = (addr_q == ADDR_LAST);
    assign iss_sol  = (x_q == '0);
    assign iss_eol  = (x_q == X_LAST);
    assign iss_eof  = iss_eol && (y_q == Y_LAST);
    assign eof_xfer = !fifo_empty && pix_ready && head_ent.eof;

    // Frame sequencing: raster counters advance per issued read; drain ends with the eof transfer,
    // which is exactly when the FIFO and the read pipeline have gone empty.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    if (last) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                    if (iss_eol) begin
                        x_d = '0;
                        y_d = y_q + Y_ONE;
                    end else begin
                        x_d = x_q + X_ONE;
                    end
                end
            end
            DRAIN: begin
                if (eof_xfer) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d      = IDLE;
            addr_d       = '0;
            x_d          = '0;
            y_d          = '0;
            frame_done_d = 1'b0;
        end
    end

    // Read-pipeline shadow: valid and raster flags ride alongside the BSRAM access.
    always_comb begin
        dl_d[0] = '{vld: issue, sol: iss_sol, eol: iss_eol, eof: iss_eof};
        for (int i = 1; i < RD_LAT; i++) dl_d[i] = dl_q[i-1];
        if (abort) begin
            for (int i = 0; i < RD_LAT; i++) dl_d[i] = '0;
        end
    end

    // Control and pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) dl_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            dl_q         <= dl_d;
        end
    end

    assign push_ent = '{data: fb_dout, sol: dl_q[RD_LAT-1].sol,
                        eol: dl_q[RD_LAT-1].eol, eof: dl_q[RD_LAT-1].eof};

    fb_fifo #(.W(FW), .D(FIFO_D)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .flush    (abort),
        .push_vld (dl_q[RD_LAT-1].vld),
        .push_dat (push_ent),
        .pop_rdy  (pix_ready),
        .head_dat (head_ent),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign fb_ce      = issue;
    assign fb_addr    = addr_q;
    assign pix_valid  = !fifo_empty;
    assign pix_data   = pix_valid ? head_ent.data : '0;
    assign pix_sol    = pix_valid && head_ent.sol;
    assign pix_eol    = pix_valid && head_ent.eol;
    assign pix_eof    = pix_valid && head_ent.eof;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
endmodule
